data_mem_ctrl: RTL and testbench

Parametrised single-port data memory controller for the datapath's load/store stage. It replaces the fixed 8-bit by 256-word data memory with configurable width and depth, and adds a valid/ready request handshake and a registered read response with one-cycle latency. Reset and software clear use a sequential sweep FSM instead of a single-cycle wipe. Optional per-word parity is selected at compile time.

---
 rtl/data_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: valid/ready requests, 1-cycle registered read
// response, sequential clear sweep. Define DATA_MEM_PARITY_EN for per-word even parity.
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_perr_inj,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef DATA_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;

  // Stored word is {parity, data}; inj flips the parity bit.
  function automatic logic [WORD_W-1:0] encode_f(input logic [DATA_W-1:0] d, input logic inj);
    return {(^d) ^ inj, d};
  endfunction

  function automatic logic check_f(input logic [WORD_W-1:0] w);
    return (^w[DATA_W-1:0]) != w[DATA_W];
  endfunction
`else
  localparam int WORD_W = DATA_W;

  function automatic logic [WORD_W-1:0] encode_f(input logic [DATA_W-1:0] d);
    return d;
  endfunction

  logic unused_perr_inj_s;
  assign unused_perr_inj_s = req_perr_inj;
`endif

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_perr_q, rsp_perr_d;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [WORD_W-1:0] mem_wword_s;
  logic [WORD_W-1:0] rd_word_s;
  logic              hs_s;

  assign req_ready = (state_q == IDLE);
  assign hs_s      = req_valid && req_ready;
  assign rd_word_s = mem_q[req_addr];

  // Next-state, sweep counter, memory write port and response computation.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_perr_d  = rsp_perr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_cnt_q;
`ifdef DATA_MEM_PARITY_EN
    mem_wword_s = encode_f({DATA_W{1'b0}}, 1'b0);
`else
    mem_wword_s = encode_f({DATA_W{1'b0}});
`endif
    case (state_q)
      CLEAR: begin
        mem_we_s  = !rst;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        clr_cnt_d = {ADDR_W{1'b0}};
        if (hs_s && req_we) begin
          mem_we_s    = !rst;
          mem_waddr_s = req_addr;
`ifdef DATA_MEM_PARITY_EN
          mem_wword_s = encode_f(req_wdata, req_perr_inj);
`else
          mem_wword_s = encode_f(req_wdata);
`endif
        end else if (hs_s) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_word_s[DATA_W-1:0];
`ifdef DATA_MEM_PARITY_EN
          rsp_perr_d  = check_f(rd_word_s);
`else
          rsp_perr_d  = 1'b0;
`endif
        end else begin
          rsp_valid_d = 1'b0;
        end
        // A same-cycle request still completes; the sweep starts on the next edge.
        if (clr_start) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  // Storage array; contents are defined only by the sweep and by writes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wword_s;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (DATA_W=8, ADDR_W=4).
module tb_data_mem_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_start;
  logic              busy;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_perr_inj;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_perr;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_perr_inj(req_perr_inj),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_inj_perr;
  int   cnt;
  int   rsp_seen;

  initial begin
`ifdef DATA_MEM_PARITY_EN
    exp_inj_perr = 1'b1;
`else
    exp_inj_perr = 1'b0;
`endif
    rst = 1'b1; clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 4'd0; req_wdata = 8'h00; req_perr_inj = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_perr", 32'(rsp_perr), 32'd0);

    // Sweep with a read held pending throughout
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    cnt = 0; rsp_seen = 0;
    while (!req_ready && cnt < 100) begin
      tick();
      cnt++;
      if (rsp_valid) rsp_seen++;
    end
    check_eq("sweep_len", 32'(cnt), 32'd16);
    check_eq("no_rsp_in_clear", 32'(rsp_seen), 32'd0);
    for (int a = 0; a < 16; a++) begin
      tick();
      check_eq("clr_rd_valid", 32'(rsp_valid), 32'd1);
      check_eq("clr_rd_data", 32'(rsp_rdata), 32'd0);
      if (a < 15) req_addr = 4'(a + 1);
      else req_valid = 1'b0;
    end
    tick();
    check_eq("idle_no_rsp", 32'(rsp_valid), 32'd0);

    // Write then read-after-write, back-to-back reads, hold
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    tick();
    check_eq("wr_no_rsp", 32'(rsp_valid), 32'd0);
    req_we = 1'b0;
    tick();
    check_eq("raw_valid", 32'(rsp_valid), 32'd1);
    check_eq("raw_data", 32'(rsp_rdata), 32'hA5);
    req_addr = 4'd4;
    tick();
    check_eq("b2b_valid", 32'(rsp_valid), 32'd1);
    check_eq("b2b_data4", 32'(rsp_rdata), 32'h00);
    req_addr = 4'd3;
    tick();
    check_eq("b2b_data3", 32'(rsp_rdata), 32'hA5);
    req_valid = 1'b0;
    tick();
    check_eq("hold_valid", 32'(rsp_valid), 32'd0);
    check_eq("hold_data", 32'(rsp_rdata), 32'hA5);

    // clr_start together with a read of addr 3
    req_valid = 1'b1; req_addr = 4'd3; clr_start = 1'b1;
    tick();
    req_valid = 1'b0; clr_start = 1'b0;
    check_eq("clr_rd_valid", 32'(rsp_valid), 32'd1);
    check_eq("clr_rd_pre", 32'(rsp_rdata), 32'hA5);
    check_eq("clr_busy", 32'(busy), 32'd1);
    check_eq("clr_ready", 32'(req_ready), 32'd0);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check_eq("clr_busy_len", 32'(cnt), 32'd16);
    req_valid = 1'b1; req_addr = 4'd3;
    tick();
    req_valid = 1'b0;
    check_eq("post_clr_valid", 32'(rsp_valid), 32'd1);
    check_eq("post_clr_data", 32'(rsp_rdata), 32'h00);

    // Reset at clr_cnt = 9 restarts the sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_busy", 32'(busy), 32'd1);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; cnt = 0;
    while (!req_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check_eq("mid_rst_sweep", 32'(cnt), 32'd16);

    // Parity injection and clean rewrite
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C; req_perr_inj = 1'b1;
    tick();
    req_we = 1'b0; req_perr_inj = 1'b0;
    tick();
    check_eq("inj_data", 32'(rsp_rdata), 32'h3C);
    check_eq("inj_perr", 32'(rsp_perr), 32'(exp_inj_perr));
    req_we = 1'b1;
    tick();
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    check_eq("clean_valid", 32'(rsp_valid), 32'd1);
    check_eq("clean_perr", 32'(rsp_perr), 32'd0);

    // Reset coinciding with a read handshake suppresses the response
    req_valid = 1'b1; req_addr = 4'd9; rst = 1'b1;
    tick();
    req_valid = 1'b0; rst = 1'b0;
    check_eq("rst_rsp_supp", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata_clr", 32'(rsp_rdata), 32'd0);
    tick();
    check_eq("rst_rsp_late", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
